// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: ISA field positions, widths,
// FSM states and the redirect-control bundle handed to the next-PC logic.
package instr_fetch_pkg;
  localparam int PC_W      = 8;
  localparam int INSTR_W   = 8;
  localparam int OPC_MSB   = 7;
  localparam int OPC_LSB   = 5;
  localparam int FUNCT_BIT = 4;
  localparam int IMM_MSB   = 3;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE, S_HALT} fetch_state_e;

  typedef struct packed {
    logic jr;
    logic j;
    logic jal;
    logic beq;
    logic zero;
  } redirect_t;

  function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ack bus; master is the fetch stage.
interface instr_fetch_if;
  import instr_fetch_pkg::*;
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection: jr > j/jal > beq-taken > sequential.
module instr_fetch_pc_next
  import instr_fetch_pkg::*;
(
  input  logic [PC_W-1:0]  pc_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [PC_W-1:0]  jr_target_i,
  input  redirect_t        redir_i,
  output logic [PC_W-1:0]  next_pc_o
);
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] rel_pc;

  assign seq_pc = pc_i + PC_W'(1);
  assign rel_pc = seq_pc + sext_imm(imm_i);

  always_comb begin
    next_pc_o = seq_pc;
    if (redir_i.jr)                     next_pc_o = jr_target_i;
    else if (redir_i.j || redir_i.jal)  next_pc_o = rel_pc;
    else if (redir_i.beq && redir_i.zero) next_pc_o = rel_pc;
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns PC and IR, fetches one instruction at a time over the
// imem req/ack bus and redirects the PC when the current instruction retires.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  instr_fetch_if.master            imem,
  input  logic                     advance_i,
  input  logic                     jctrl_i,
  input  logic                     jalctrl_i,
  input  logic                     jrctrl_i,
  input  logic                     beqctrl_i,
  input  logic                     zero_i,
  input  logic [PC_W-1:0]          jr_target_i,
  output logic [OPC_MSB-OPC_LSB:0] inst1_o,
  output logic                     inst2_o,
  output logic [IMM_W-1:0]         imm_o,
  output logic                     ir_valid_o,
  output logic [PC_W-1:0]          link_pc_o,
  output logic                     fetch_err_o
);
  // Fault fires on the no-ack cycle whose increment would reach MAX_WAIT.
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         wait_q, wait_d;
  logic               err_q, err_d;
  logic [PC_W-1:0]    next_pc;
  redirect_t          redir;

  assign redir = '{jr: jrctrl_i, j: jctrl_i, jal: jalctrl_i, beq: beqctrl_i, zero: zero_i};

  instr_fetch_pc_next u_pc_next (
    .pc_i        (pc_q),
    .imm_i       (ir_q[IMM_MSB:IMM_LSB]),
    .jr_target_i (jr_target_i),
    .redir_i     (redir),
    .next_pc_o   (next_pc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        wait_d  = '0;
      end
      S_REQ: begin
        if (imem.ack) begin
          ir_d    = imem.rdata;
          wait_d  = '0;
          state_d = S_ISSUE;
        end else begin
          wait_d = wait_q + 4'd1;
          if (wait_q == WAIT_LAST) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_ISSUE: begin
        if (advance_i) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase
  end

  assign imem.req    = (state_q == S_REQ);
  assign imem.addr   = pc_q;
  assign ir_valid_o  = (state_q == S_ISSUE);
  assign fetch_err_o = err_q;
  assign inst1_o     = ir_q[OPC_MSB:OPC_LSB];
  assign inst2_o     = ir_q[FUNCT_BIT];
  assign imm_o       = ir_q[IMM_MSB:IMM_LSB];
  assign link_pc_o   = pc_q + PC_W'(1);
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed corner cases plus randomized fetch/retire
// traffic checked against a transaction-level PC model.
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       advance = 1'b0, jctrl = 1'b0, jalctrl = 1'b0, jrctrl = 1'b0;
  logic       beqctrl = 1'b0, zero = 1'b0;
  logic [7:0] jr_target = 8'h00;
  logic [2:0] inst1;
  logic       inst2;
  logic [3:0] imm;
  logic       ir_valid;
  logic [7:0] link_pc;
  logic       fetch_err;

  instr_fetch_if imem();

  instr_fetch #(.RESET_PC(8'h00), .MAX_WAIT(15)) dut (
    .clk_i(clk), .rst_ni(rst_n), .imem(imem),
    .advance_i(advance), .jctrl_i(jctrl), .jalctrl_i(jalctrl), .jrctrl_i(jrctrl),
    .beqctrl_i(beqctrl), .zero_i(zero), .jr_target_i(jr_target),
    .inst1_o(inst1), .inst2_o(inst2), .imm_o(imm), .ir_valid_o(ir_valid),
    .link_pc_o(link_pc), .fetch_err_o(fetch_err)
  );

  always #5 clk = ~clk;

  int         errs = 0;
  int         nchk = 0;
  int         exp_pc = 0;
  logic [7:0] cur_ir = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Architectural next-PC rule, straight from the ISA description.
  function automatic int model_next(input int pc, input logic [7:0] ir, input logic jr,
                                    input logic jmp, input logic beq, input logic z,
                                    input logic [7:0] tgt);
    int off;
    off = ir[3] ? int'(ir[3:0]) - 16 : int'(ir[3:0]);
    if (jr) return int'(tgt);
    if (jmp || (beq && z)) return (pc + 1 + off + 256) % 256;
    return (pc + 1) % 256;
  endfunction

  task automatic fetch(input logic [7:0] rd, input int dly, input bit stray);
    int n = 0;
    while (!imem.req && n < 4) begin tick; n++; end
    chk("req_seen", imem.req, 1);
    chk("imem_addr", imem.addr, exp_pc);
    for (int i = 0; i < dly; i++) begin
      if (stray) advance = 1'b1;
      tick;
      advance = 1'b0;
      chk("req_hold", {imem.req, imem.addr}, {1'b1, 8'(exp_pc)});
    end
    imem.ack = 1'b1; imem.rdata = rd;
    tick;
    imem.ack = 1'b0; imem.rdata = 8'($urandom);
    cur_ir = rd;
    chk("ir_valid", ir_valid, 1);
    chk("req_drop", imem.req, 0);
    chk("fields", {inst1, inst2, imm}, rd);
    chk("link_pc", link_pc, (exp_pc + 1) % 256);
    if (stray) begin
      imem.ack = 1'b1; imem.rdata = ~rd;
      tick;
      imem.ack = 1'b0;
      chk("ir_hold", {ir_valid, inst1, inst2, imm}, {1'b1, rd});
    end
  endtask

  task automatic retire(input logic jr, input logic j, input logic jal, input logic beq,
                        input logic z, input logic [7:0] tgt);
    jrctrl = jr; jctrl = j; jalctrl = jal; beqctrl = beq; zero = z; jr_target = tgt;
    advance = 1'b1;
    exp_pc = model_next(exp_pc, cur_ir, jr, j | jal, beq, z, tgt);
    tick;
    advance = 1'b0; jrctrl = 1'b0; jctrl = 1'b0; jalctrl = 1'b0; beqctrl = 1'b0; zero = 1'b0;
    chk("ir_valid_clr", ir_valid, 0);
    chk("next_req", imem.req, 1);
    chk("next_addr", imem.addr, exp_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errs, nchk);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    imem.ack = 1'b0; imem.rdata = 8'h00;
    repeat (2) tick;
    chk("rst_outs", {imem.req, ir_valid, fetch_err, inst1, inst2, imm}, 0);
    chk("rst_pc", imem.addr, 8'h00);
    rst_n = 1'b1;
    tick;
    chk("req_cycle1", imem.req, 1);

    // Sequential stream of 8'h6A
    fetch(8'h6A, 0, 0);
    chk("f6A", {inst1, inst2, imm}, {3'b011, 1'b0, 4'b1010});
    retire(0, 0, 0, 0, 0, 8'h00);
    chk("seq01", imem.addr, 8'h01);
    fetch(8'h6A, 0, 0);
    retire(0, 0, 0, 0, 0, 8'h00);
    chk("seq02", imem.addr, 8'h02);

    // Wrap FF -> 00
    fetch(8'h00, 1, 0); retire(1, 0, 0, 0, 0, 8'hFF);
    fetch(8'h00, 0, 0); retire(0, 0, 0, 0, 0, 8'h00);
    chk("wrap", imem.addr, 8'h00);

    // Relative jump, then untaken beq
    fetch(8'h00, 0, 0); retire(1, 0, 0, 0, 0, 8'h10);
    fetch(8'h0E, 0, 0); retire(0, 1, 0, 0, 0, 8'h00);
    chk("j_back", imem.addr, 8'h0F);
    fetch(8'h00, 0, 0); retire(1, 0, 0, 0, 0, 8'h10);
    fetch(8'h0E, 0, 0); retire(0, 0, 0, 1, 0, 8'h00);
    chk("beq_nt", imem.addr, 8'h11);

    // jr wins over j; jal link address
    fetch(8'h05, 0, 0); retire(1, 1, 0, 0, 0, 8'h80);
    chk("jr_prio", imem.addr, 8'h80);
    fetch(8'h00, 0, 0); retire(1, 0, 0, 0, 0, 8'h20);
    fetch(8'hA3, 0, 0);
    chk("jal_link", link_pc, 8'h21);
    retire(0, 0, 1, 1, 1, 8'h00);
    chk("jal_tgt", imem.addr, 8'h24);

    // Ack on the last allowed cycle, then a real timeout
    fetch(8'h11, 14, 0);
    chk("no_fault", fetch_err, 0);
    retire(0, 0, 0, 0, 0, 8'h00);
    repeat (15) tick;
    chk("timeout", {fetch_err, imem.req, ir_valid}, 3'b100);
    imem.ack = 1'b1;
    repeat (4) tick;
    imem.ack = 1'b0;
    chk("halt_stuck", {fetch_err, imem.req, ir_valid}, 3'b100);

    // Reset from halt, with stray ack/advance while held
    rst_n = 1'b0; #1;
    chk("rst_halt", {fetch_err, imem.req, ir_valid, imem.addr}, 0);
    imem.ack = 1'b1; advance = 1'b1;
    repeat (2) tick;
    chk("rst_stray", {imem.req, ir_valid, fetch_err}, 0);
    imem.ack = 1'b0; advance = 1'b0;
    rst_n = 1'b1; exp_pc = 0;
    tick;
    chk("rst_rel", imem.req, 1);

    // Reset in S_REQ
    fetch(8'h00, 0, 0); retire(1, 0, 0, 0, 0, 8'h44);
    rst_n = 1'b0; #1;
    chk("rst_req", {imem.req, ir_valid, imem.addr}, 0);
    imem.ack = 1'b1; imem.rdata = 8'hFF;
    tick;
    imem.ack = 1'b0; rst_n = 1'b1; exp_pc = 0;
    tick;
    chk("rst_req_ir", {imem.req, inst1, inst2, imm}, {1'b1, 8'h00});

    // Reset in S_ISSUE
    fetch(8'hC7, 2, 0);
    rst_n = 1'b0; #1;
    chk("rst_iss", {imem.req, ir_valid, imem.addr, inst1, inst2, imm}, 0);
    advance = 1'b1;
    tick;
    advance = 1'b0; rst_n = 1'b1; exp_pc = 0;
    tick;
    chk("rst_iss_rel", {imem.req, imem.addr}, {1'b1, 8'h00});

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom;
      fetch(8'($urandom), int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
      retire(r[0] & r[1], r[2] & r[3], r[4] & r[5], r[6], r[7], r[15:8]);
      chk("rnd_err", fetch_err, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
